// File: rtl/muldiv_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side drives start/op/operands/flush and observes busy/done/res.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] res;

   modport master (output start, op, op_a, op_b, flush, input busy, done, res);
   modport slave  (input start, op, op_a, op_b, flush, output busy, done, res);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied once in a final FIX cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input logic     CLK,
   input logic     nrst,
   muldiv_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_q;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opb_q;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   res_q;
   logic              done_q;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
      return ({XLEN{n}} ^ v) + XLEN'(n);
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic n);
      return ({(2*XLEN){n}} ^ v) + (2*XLEN)'(n);
   endfunction

   // Operand decode at start: signedness, magnitudes and fast-path detection.
   logic            a_signed, b_signed;
   logic            a_neg_c, b_neg_c;
   logic            div_zero, div_ovf, fast_c;
   logic [XLEN-1:0] fast_res;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      a_neg_c  = a_signed & bus.op_a[XLEN-1];
      b_neg_c  = b_signed & bus.op_b[XLEN-1];
      div_zero = bus.op[2] && (bus.op_b == '0);
      div_ovf  = (bus.op == OP_DIV || bus.op == OP_REM) &&
                 (bus.op_a == MOST_NEG) && (bus.op_b == '1);
      fast_c   = div_zero || div_ovf;
      if (div_zero) fast_res = bus.op[1] ? bus.op_a : '1;
      else          fast_res = bus.op[1] ? '0 : bus.op_a;
   end

   // One radix-2 step; acc holds {product} for multiply, {remainder, quotient} for divide.
   logic [XLEN:0]     add_sum;
   logic [XLEN:0]     trial;
   logic [2*XLEN-1:0] acc_step;

   always_comb begin
      add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
      trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb_q};
      if (!op_q[2])      acc_step = {add_sum, acc[XLEN-1:1]};
      else if (trial[XLEN]) acc_step = {acc[2*XLEN-2:0], 1'b0};
      else               acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      prod_fix = cond_neg_w(acc, a_neg ^ b_neg);
      case (op_q)
         OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = cond_neg(acc[XLEN-1:0], a_neg ^ b_neg);
         default:                      fix_res = cond_neg(acc[2*XLEN-1:XLEN], a_neg);
      endcase
   end

   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         acc    <= '0;
         opb_q  <= '0;
         a_neg  <= 1'b0;
         b_neg  <= 1'b0;
         res_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (bus.start) begin
                     op_q  <= bus.op;
                     a_neg <= a_neg_c;
                     b_neg <= b_neg_c;
                     acc   <= {{XLEN{1'b0}}, cond_neg(bus.op_a, a_neg_c)};
                     opb_q <= cond_neg(bus.op_b, b_neg_c);
                     cnt   <= '0;
                     if (fast_c) begin
                        res_q  <= fast_res;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                     end else begin
                        state <= S_CALC;
                     end
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_CALC: begin
                  acc <= acc_step;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
               end
               default: begin
                  res_q  <= fix_res;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            endcase
         end
      end
   end

   assign bus.busy = (state == S_CALC) || (state == S_FIX);
   assign bus.done = done_q;
   assign bus.res  = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized operations
// checked against a plain-arithmetic reference model, including latency of each result.
module tb_muldiv_unit;
   localparam int XLEN = 32;

   logic CLK = 1'b0;
   logic nrst = 1'b0;
   int   cyc = 0;

   muldiv_if #(.XLEN(XLEN)) bus ();
   muldiv_unit #(.XLEN(XLEN)) dut (.CLK(CLK), .nrst(nrst), .bus(bus));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      logic [2:0]  op;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_res = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sbv, ua, ub;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      case (op)
         3'd0: begin p = 64'(sa * sbv); return p[31:0]; end
         3'd1: begin p = 64'(sa * sbv); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sbv);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sbv);
         end
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge CLK) begin : monitor
      exp_t e;
      if (nrst && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk($sformatf("res_op%0d", e.op), bus.res, e.res);
            chk($sformatf("done_cycle_op%0d", e.op), 32'(cyc), 32'(e.cyc));
            last_res = e.res;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      if (push) begin
         e.res = ref_model(op, a, b);
         e.cyc = cyc + (is_fast(op, a, b) ? 1 : XLEN + 2);
         e.op  = op;
         sb.push_back(e);
      end
      bus.start = 1'b1;
      bus.op    = op;
      bus.op_a  = a;
      bus.op_b  = b;
   endtask

   task automatic wait_done(input bit fast);
      int n;
      n = 0;
      @(negedge CLK);
      bus.start = 1'b0;
      chk(fast ? "fast_busy" : "calc_busy", 32'(bus.busy), fast ? 32'd0 : 32'd1);
      while (!bus.done && n < XLEN + 8) begin
         @(negedge CLK);
         n++;
      end
      if (!bus.done) begin
         checks++;
         failures++;
         $display("FAIL timeout actual=no_done required=done (cycle %0d)", cyc);
         sb.delete();
      end
   endtask

   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge CLK);
      issue(op, a, b, 1'b1);
      wait_done(is_fast(op, a, b));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int          s;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.flush = 1'b0;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_res", bus.res, 0);
      nrst = 1'b1;
      @(negedge CLK);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_res", bus.res, 0);

      // T1: multiply family
      for (int k = 0; k < 4; k++) run(3'(k), 32'hC0E1_9800, 32'hEEE1_9000);

      // T2: signed/unsigned divide and remainder of -7 by 2
      for (int k = 4; k < 8; k++) run(3'(k), 32'hFFFF_FFF9, 32'h0000_0002);

      // T3: fast paths
      run(3'd5, 32'h1234_5678, 32'h0);
      run(3'd7, 32'h1234_5678, 32'h0);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      run(3'd4, 32'h0000_0005, 32'h0);
      run(3'd6, 32'hFFFF_FFF0, 32'h0);

      // T4: flush in cycle 10 of a DIV, restart in cycle 12
      @(negedge CLK);
      s = cyc;
      issue(3'd4, 32'h0000_1234, 32'h0000_0007, 1'b0);
      @(negedge CLK);
      bus.start = 1'b0;
      repeat (9) @(negedge CLK);
      bus.flush = 1'b1;
      @(negedge CLK);
      bus.flush = 1'b0;
      chk("flush_cycle", 32'(cyc - s), 11);
      chk("flush_busy", 32'(bus.busy), 0);
      chk("flush_res_held", bus.res, last_res);
      @(negedge CLK);
      issue(3'd4, 32'h0000_1234, 32'h0000_0007, 1'b1);
      wait_done(1'b0);

      // T5: start during CALC is ignored; back-to-back start in DONE is accepted
      @(negedge CLK);
      issue(3'd6, 32'h8765_4321, 32'h0000_0013, 1'b1);
      @(negedge CLK);
      bus.start = 1'b0;
      repeat (3) @(negedge CLK);
      bus.start = 1'b1;
      bus.op    = 3'd0;
      bus.op_a  = 32'h1111_1111;
      bus.op_b  = 32'h0;
      wait_done(1'b0);
      issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done(1'b0);
      issue(3'd5, 32'hDEAD_BEEF, 32'h0, 1'b1);
      wait_done(1'b1);

      // T6: asynchronous reset mid-CALC
      @(negedge CLK);
      issue(3'd0, 32'hC0E1_9800, 32'hEEE1_9000, 1'b1);
      @(negedge CLK);
      bus.start = 1'b0;
      repeat (10) @(negedge CLK);
      #2;
      nrst = 1'b0;
      sb.delete();
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_done", 32'(bus.done), 0);
      chk("arst_res", bus.res, 0);
      last_res = '0;
      @(negedge CLK);
      nrst = 1'b1;
      run(3'd0, 32'hC0E1_9800, 32'hEEE1_9000);
      repeat (3) @(negedge CLK);
      chk("res_held_idle", bus.res, last_res);

      // Randomized operations, some issued back-to-back in the DONE cycle
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = pick();
         rb  = pick();
         if (i > 0 && $urandom_range(0, 1) == 1) begin
            issue(rop, ra, rb, 1'b1);
            wait_done(is_fast(rop, ra, rb));
         end else begin
            run(rop, ra, rb);
         end
      end

      repeat (5) @(negedge CLK);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
